// File: rtl/awgn_pkg.sv
// Shared constants and helpers for the AWGN noise injector: gain Q-format, saturation, level width.
package awgn_pkg;

  // Unsigned Q1.(gw-1) gain: this value represents 1.0.
  function automatic longint gain_one(input int gw);
    return longint'(1) <<< (gw - 1);
  endfunction

  // Half an LSB of the scaled result, added before the truncating shift (round-half-up).
  function automatic longint gain_rnd(input int gw);
    return longint'(1) <<< (gw - 2);
  endfunction

  // Width of a level counter that can hold 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Saturation of a wide signed sum to dw bits: returns {above_max, below_min}.
  function automatic logic [1:0] sat_flags(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    return {v > hi, v < (-hi - 64'sd1)};
  endfunction

endpackage

// File: rtl/awgn_noise_fifo.sv
// Noise sample FIFO: writes a pair (x0 then x1) per cycle, reads one sample per cycle.
// Read data is the registered head; a write at edge N is readable after edge N.
module awgn_noise_fifo
  import awgn_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_dat0,
  input  logic [W-1:0]               wr_dat1,
  output logic                       wr_rdy,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_dat,
  output logic [level_w(DEPTH)-1:0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr]          <= wr_dat0;
      mem[wr_ptr + AW'(1)] <= wr_dat1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(2);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      level <= level + (wr_en ? LW'(2) : LW'(0)) - (rd_en ? LW'(1) : LW'(0));
    end
  end

  assign rd_dat = mem[rd_ptr];
  // Room for a full pair, judged on the registered level only.
  assign wr_rdy = (level <= LW'(DEPTH - 2));

endmodule

// File: rtl/awgn_noise_injector.sv
// Adds gain-scaled AWGN samples to a valid/ready stream with rounding and saturation (sat_count: AWGN_SAT_CNT_EN).
// Latency 2 cycles (S1 multiply register, S2 add/saturate output register); 1 sample/cycle.
// Backpressure: m_valid & !m_ready stalls both stages and drops s_ready combinationally.
module awgn_noise_injector
  import awgn_pkg::*;
#(
  parameter int DW    = 16,
  parameter int NW    = 16,
  parameter int GW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [GW-1:0]              gain,
  input  logic [NW-1:0]              noise_in0,
  input  logic [NW-1:0]              noise_in1,
  input  logic                       noise_valid,
  output logic                       noise_ready,
  input  logic [DW-1:0]              s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [DW-1:0]              m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [level_w(DEPTH)-1:0]  fifo_level
`ifdef AWGN_SAT_CNT_EN
  ,
  output logic [31:0]                sat_count
`endif
);

  localparam int PW  = NW + GW + 1;
  localparam int SCW = NW + 1;
  localparam int SW  = ((DW > SCW) ? DW : SCW) + 1;
  localparam logic signed [PW-1:0] RND  = PW'(gain_rnd(GW));
  localparam logic [DW-1:0]        DMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]        DMIN = {1'b1, {(DW-1){1'b0}}};

  typedef struct packed {
    logic           vld;
    logic [DW-1:0]  dat;
    logic [SCW-1:0] scaled;
  } s1_t;

  logic                  run;
  logic                  stall;
  logic                  accept;
  logic                  pop;
  logic                  wr_rdy;
  logic                  fifo_wr;
  logic [NW-1:0]         noise_head;
  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  prod_rnd;
  logic signed [SCW-1:0] scaled_c;
  logic signed [SW-1:0]  sum;
  logic [1:0]            sat;
  logic [DW-1:0]         clip;
  s1_t                   s1;

  // Holds both ready outputs low until the first edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) run <= 1'b0;
    else       run <= 1'b1;
  end

  assign noise_ready = run & wr_rdy;
  assign fifo_wr     = noise_valid & noise_ready;
  assign stall       = m_valid & ~m_ready;
  assign s_ready     = run & ~stall & (~enable | (fifo_level != '0));
  assign accept      = s_valid & s_ready;
  assign pop         = accept & enable;

  awgn_noise_fifo #(.W(NW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_dat0 (noise_in0),
    .wr_dat1 (noise_in1),
    .wr_rdy  (wr_rdy),
    .rd_en   (pop),
    .rd_dat  (noise_head),
    .level   (fifo_level)
  );

  assign prod     = PW'($signed(noise_head)) * PW'($signed({1'b0, gain}));
  assign prod_rnd = prod + RND;
  assign scaled_c = SCW'(prod_rnd >>> (GW - 1));

  assign sum  = SW'($signed(s1.dat)) + SW'($signed(s1.scaled));
  assign sat  = sat_flags(64'(sum), DW);
  assign clip = sat[1] ? DMAX : (sat[0] ? DMIN : sum[DW-1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1      <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (!stall) begin
      m_valid <= s1.vld;
      if (s1.vld) m_data <= clip;
      s1.vld <= accept;
      if (accept) begin
        s1.dat    <= s_data;
        s1.scaled <= enable ? scaled_c : '0;
      end
    end
  end

`ifdef AWGN_SAT_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_count <= '0;
    end else if (!stall && s1.vld && (sat != 2'b00) && (sat_count != '1)) begin
      sat_count <= sat_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_awgn_noise_injector.sv
// Scoreboard bench for awgn_noise_injector: directed vectors, expected outputs queued at acceptance.
module tb_awgn_noise_injector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] gain = 16'h8000;
  logic [15:0] noise_in0 = '0;
  logic [15:0] noise_in1 = '0;
  logic        noise_valid = 1'b0;
  logic        noise_ready;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [3:0]  fifo_level;
`ifdef AWGN_SAT_CNT_EN
  logic [31:0] sat_count;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  awgn_noise_injector #(.DW(16), .NW(16), .GW(16), .DEPTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .gain        (gain),
    .noise_in0   (noise_in0),
    .noise_in1   (noise_in1),
    .noise_valid (noise_valid),
    .noise_ready (noise_ready),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .fifo_level  (fifo_level)
`ifdef AWGN_SAT_CNT_EN
    ,
    .sat_count   (sat_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    noise_in0   = a;
    noise_in1   = b;
    noise_valid = 1'b1;
    @(negedge clk);
    while (!noise_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("pair_accept", 32'(noise_ready), 32'h1);
    @(posedge clk);
    #1;
    noise_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic [15:0] g, input logic en,
                      input logic [15:0] exp);
    int n;
    n = 0;
    s_data  = d;
    gain    = g;
    enable  = en;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", 32'(s_ready), 32'h1);
    if (s_ready) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      forever begin
        logic [15:0] e;
        @(negedge clk);
        if (!reset && m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got 0x%0h with no sample outstanding", m_data);
          end else begin
            e = exp_q.pop_front();
            chk("m_data", 32'(m_data), 32'(e));
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_noise_ready", 32'(noise_ready), 32'h0);
    chk("rst_s_ready", 32'(s_ready), 32'h0);
    chk("rst_m_valid", 32'(m_valid), 32'h0);
    chk("rst_m_data", 32'(m_data), 32'h0);
    chk("rst_fifo_level", 32'(fifo_level), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("nrdy_before_edge", 32'(noise_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("nrdy_after_edge", 32'(noise_ready), 32'h1);

    // Unity gain, pair order x0 then x1
    push_pair(16'h0100, 16'h0040);
    chk("level_one_pair", 32'(fifo_level), 32'h2);
    send(16'h1000, 16'h8000, 1'b1, 16'h1100);
    send(16'h1000, 16'h8000, 1'b1, 16'h1040);
    drain();
    chk("level_after_pair", 32'(fifo_level), 32'h0);

    // Round-half-up at gain 0.5
    push_pair(16'h0003, 16'hFFFD);
    send(16'h0000, 16'h4000, 1'b1, 16'h0002);
    send(16'h0000, 16'h4000, 1'b1, 16'hFFFF);
    drain();

    // Saturation at both rails
    push_pair(16'h0200, 16'hFE00);
    send(16'h7F00, 16'h8000, 1'b1, 16'h7FFF);
    send(16'h8100, 16'h8000, 1'b1, 16'h8000);
    drain();
`ifdef AWGN_SAT_CNT_EN
    chk("sat_count", sat_count, 32'h2);
`endif

    // Empty FIFO blocks enabled input; bypass passes through without popping
    enable  = 1'b1;
    s_data  = 16'h0777;
    s_valid = 1'b1;
    @(negedge clk);
    chk("s_ready_empty", 32'(s_ready), 32'h0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    send(16'h1234, 16'h8000, 1'b0, 16'h1234);
    drain();
    chk("bypass_level_empty", 32'(fifo_level), 32'h0);
    push_pair(16'h0010, 16'h0020);
    send(16'h5555, 16'h8000, 1'b0, 16'h5555);
    drain();
    chk("bypass_level_kept", 32'(fifo_level), 32'h2);
    send(16'h0001, 16'h8000, 1'b1, 16'h0011);
    send(16'h0001, 16'h8000, 1'b1, 16'h0021);
    drain();

    // Backpressure: output held, input blocked, FIFO untouched
    push_pair(16'h0001, 16'h0002);
    push_pair(16'h0003, 16'h0004);
    m_ready = 1'b0;
    send(16'h0100, 16'h8000, 1'b1, 16'h0101);
    send(16'h0100, 16'h8000, 1'b1, 16'h0102);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_m_data", 32'(m_data), 32'h0101);
      chk("stall_m_valid", 32'(m_valid), 32'h1);
      chk("stall_s_ready", 32'(s_ready), 32'h0);
      chk("stall_level", 32'(fifo_level), 32'h2);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    send(16'h0100, 16'h8000, 1'b1, 16'h0103);
    send(16'h0100, 16'h8000, 1'b1, 16'h0104);
    drain();
    chk("bp_level_final", 32'(fifo_level), 32'h0);

    // FIFO fill to DEPTH
    push_pair(16'h0010, 16'h0020);
    push_pair(16'h0030, 16'h0040);
    push_pair(16'h0050, 16'h0060);
    push_pair(16'h0070, 16'h0080);
    @(negedge clk);
    chk("full_level", 32'(fifo_level), 32'h8);
    chk("full_noise_ready", 32'(noise_ready), 32'h0);
    noise_in0   = 16'h0BAD;
    noise_in1   = 16'h0BAD;
    noise_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    noise_valid = 1'b0;
    chk("full_no_overwrite", 32'(fifo_level), 32'h8);

    // Reset with samples in flight
    send(16'h0000, 16'h8000, 1'b1, 16'h0010);
    send(16'h0000, 16'h8000, 1'b1, 16'h0020);
    send(16'h0000, 16'h8000, 1'b1, 16'h0030);
    chk("level_before_reset", 32'(fifo_level), 32'h5);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_m_valid", 32'(m_valid), 32'h0);
    chk("midrst_level", 32'(fifo_level), 32'h0);
    chk("midrst_s_ready", 32'(s_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("post_rst_idle", 32'(m_valid), 32'h0);

    // Normal operation resumes from clean pointers
    @(posedge clk);
    #1;
    push_pair(16'h0005, 16'h0006);
    send(16'h0100, 16'h8000, 1'b1, 16'h0105);
    send(16'h0100, 16'h8000, 1'b1, 16'h0106);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
